mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of client memory ports (2..16).
REQ-002 SHALL have parameter ADDR_W, default 21, physical address width (matches phys_memory_address_t).
REQ-003 SHALL have parameter DATA_W, default 64, data word width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_PORTS  per-client request valid.
REQ-007 SHALL have port req_write  input  NUM_PORTS  per-client write=1 / read=0.
REQ-008 SHALL have port req_addr  input  NUM_PORTS*ADDR_W  per-client address, port i at slice i.
REQ-009 SHALL have port req_wdata  input  NUM_PORTS*DATA_W  per-client write data, port i at slice i.
REQ-010 SHALL have port req_ready  output  NUM_PORTS  one-hot acceptance strobe.
REQ-011 SHALL have port resp_valid  output  NUM_PORTS  one-hot response strobe.
REQ-012 SHALL have port resp_rdata  output  DATA_W  shared response data.
REQ-013 SHALL have downstream ports mem_req_valid/mem_req_write (output 1), mem_req_addr (output ADDR_W), mem_req_wdata (output DATA_W), mem_req_ready (input 1), mem_resp_valid (input 1), mem_resp_rdata (input DATA_W).

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT_RESP -> IDLE; one outstanding transaction.
REQ-015 IDLE: if any req_valid, SHALL grant first set index scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_PORTS; assert req_ready[grant] combinationally that cycle; latch write/addr/wdata/grant; go ISSUE.
REQ-016 req_ready SHALL be all-zero outside IDLE and in IDLE with no req_valid.
REQ-017 ISSUE: mem_req_valid=1 with latched fields held stable until cycle mem_req_ready=1; then go WAIT_RESP.
REQ-018 WAIT_RESP: on mem_resp_valid, SHALL register mem_resp_rdata to resp_rdata and pulse resp_valid[grant] for exactly one cycle the next cycle; rr_ptr <= (grant+1) mod NUM_PORTS; go IDLE.
REQ-019 Writes SHALL also wait for mem_resp_valid (ack); resp_rdata for writes is don't-care.
REQ-020 Minimum latency: accept cycle N, mem_req_valid N+1, resp_valid earliest N+3.
REQ-021 mem_resp_valid outside WAIT_RESP SHALL be ignored.
REQ-022 A single requesting client SHALL be re-grantable in the IDLE cycle coinciding with its resp_valid pulse (back-to-back).
REQ-023 Fairness: any continuously requesting client SHALL be granted within NUM_PORTS grants.
REQ-024 resp_rdata SHALL hold its value between responses.

Reset
REQ-025 On reset: state IDLE, rr_ptr 0, mem_req_valid 0, req_ready 0, resp_valid 0, resp_rdata 0, latched fields 0.
REQ-026 Reset mid-transaction SHALL abandon it with no resp_valid pulse; late mem_resp_valid then ignored per REQ-021.

Configuration
REQ-027 With MEM_ARB_STATS_EN defined: per-port 32-bit grant_count and wait_cycles (cycles req_valid=1 without req_ready) counters, exposed as output stat_grants (NUM_PORTS*32) and stat_waits (NUM_PORTS*32), saturating at 0xFFFFFFFF, cleared by reset.
REQ-028 Without MEM_ARB_STATS_EN: counters and stat_* ports absent; function otherwise identical.

Structure
REQ-029 Shared package SHALL hold arb_state_t enum (IDLE/ISSUE/WAIT_RESP) and defaults for ADDR_W/DATA_W.
REQ-030 Round-robin priority picker SHALL be sub-module rr_picker (inputs req vector, rr_ptr; outputs one-hot grant, grant index, any).

Verification
REQ-031 Single client: port 2 reads 0x00100, mem returns 0xDEADBEEF_00000001 -> resp_valid=4'b0100, resp_rdata matches, mem_req_addr=0x00100.
REQ-032 All 4 ports request continuously after reset -> grant order 0,1,2,3,0; no port starved.
REQ-033 mem_req_ready held 0 for 5 cycles -> mem_req_* stable, req_ready all zero throughout.
REQ-034 Reset asserted in WAIT_RESP, then mem_resp_valid -> no resp_valid pulse; next request granted from port 0 priority.
REQ-035 Port 1 write 0x0ABCD, wdata 0x1122334455667788 -> mem_req_write=1, fields match; resp_valid[1] after ack.
REQ-036 MEM_ARB_STATS_EN, ports 0 and 3 request 10 transactions each -> stat_grants 10 each; stat_waits nonzero for both.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the memory port arbiter.
// The arbiter state encoding lives here so that other blocks can observe it.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_ADDR_W = 21;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned STAT_W     = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin priority picker: the first set request at or after rr_ptr wins,
// wrapping modulo N.
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos     = (32'(rr_ptr) + k) % N;
            pos_idx = IDX_W'(pos);
            if (!any && req[pos_idx]) begin
                any            = 1'b1;
                grant[pos_idx] = 1'b1;
                grant_idx      = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS client ports onto one memory port, one
// transaction outstanding. Optional per-port statistics with MEM_ARB_STATS_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          mem_req_valid,
    output logic                          mem_req_write,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_wdata,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*STAT_W-1:0]   stat_grants,
    output logic [NUM_PORTS*STAT_W-1:0]   stat_waits
`endif
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_PORTS-1:0]   pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [NUM_PORTS-1:0]   lat_grant_oh;
    logic [IDX_W-1:0]       lat_grant_idx;
    logic                   lat_write;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_wdata;

    rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Acceptance is combinational so a client sees req_ready in the same IDLE cycle.
    assign req_ready     = (state == IDLE && !reset) ? pick_oh : '0;
    assign mem_req_write = lat_write;
    assign mem_req_addr  = lat_addr;
    assign mem_req_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            mem_req_valid <= 1'b0;
            resp_valid    <= '0;
            resp_rdata    <= '0;
            lat_grant_oh  <= '0;
            lat_grant_idx <= '0;
            lat_write     <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        lat_grant_oh  <= pick_oh;
                        lat_grant_idx <= pick_idx;
                        lat_write     <= req_write[pick_idx];
                        lat_addr      <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        lat_wdata     <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        resp_rdata <= mem_resp_rdata;
                        resp_valid <= lat_grant_oh;
                        rr_ptr     <= (lat_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                               : lat_grant_idx + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_PORTS];
    logic [STAT_W-1:0] wait_cnt  [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (req_ready[i] && grant_cnt[i] != '1)
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                if (req_valid[i] && !req_ready[i] && wait_cnt[i] != '1)
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat_out
        assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
        assign stat_waits[g*STAT_W +: STAT_W]  = wait_cnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 21;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_rdata;
    logic            mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata, mem_resp_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [N*32-1:0] stat_grants, stat_waits;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_waits(stat_waits)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 21'h00100) return 64'hDEADBEEF_00000001;
        return {11'h0, a, 32'h600DF00D};
    endfunction

    // ---------------- client ports ----------------
    int            cnt  [N];
    logic          wr   [N];
    logic [AW-1:0] caddr[N];
    logic [DW-1:0] cwd  [N];

    always @(posedge clk) begin
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && cnt[i] > 0) begin
                cnt[i]--;
                caddr[i] = caddr[i] + 1'b1;
                cwd[i]   = cwd[i] + 64'h0101;
            end
            req_valid[i]             = (cnt[i] > 0);
            req_write[i]             = wr[i];
            req_addr[i*AW +: AW]     = caddr[i];
            req_wdata[i*DW +: DW]    = cwd[i];
        end
    end

    // ---------------- memory responder ----------------
    int            hold_ready = 0;
    int            resp_lat   = 0;
    int            lat_cnt    = 0;
    bit            waiting    = 0;
    bit            resp_force = 0;
    logic [AW-1:0] wait_addr  = '0;

    always @(posedge clk) begin
        bit hs, taken, rst_s;
        hs    = mem_req_valid && mem_req_ready;
        taken = waiting && mem_resp_valid;
        rst_s = reset;
        #1;
        if (rst_s) waiting = 0;
        else begin
            if (taken) waiting = 0;
            if (hs) begin
                waiting   = 1;
                lat_cnt   = resp_lat;
                wait_addr = mem_req_addr;
            end
        end
        mem_resp_valid = resp_force || (waiting && lat_cnt == 0);
        mem_resp_rdata = mem_data(wait_addr);
        if (waiting && lat_cnt > 0) lat_cnt--;
        mem_req_ready = mem_req_valid && (hold_ready == 0);
        if (mem_req_valid && hold_ready > 0) hold_ready--;
    end

    // ---------------- reference model + compare ----------------
    bit            m_busy = 0, m_issued = 0, m_rd_known = 1;
    int            m_grant = 0, m_ptr = 0;
    logic [N-1:0]  m_resp = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_write = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_grants[N], m_waits[N];

    int            cyc = 0;
    int            grant_log[$];
    int            acc_cyc[$];
    int            resp_cyc = 0, resp_pulses = 0, mrv_cycles = 0, ready_cycles = 0;
    logic [N-1:0]  seen_vec = '0;
    logic [DW-1:0] seen_rdata = '0, seen_wdata = '0;
    logic [AW-1:0] seen_addr = '0;
    logic          seen_write = 0;
    bit            prev_mrv = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int pick, p;
        cyc++;
        exp_ready = '0;
        pick = -1;
        if (!reset && !m_busy)
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (pick < 0 && req_valid[p]) pick = p;
            end
        if (pick >= 0) exp_ready[pick] = 1'b1;

        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_busy && !m_issued));
        if (m_busy && !m_issued) begin
            chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
            chk("mem_req_write", 64'(mem_req_write), 64'(m_write));
            chk("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        chk("resp_valid", 64'(resp_valid), 64'(m_resp));
        if (m_rd_known) chk("resp_rdata", resp_rdata, m_rdata);

        if (pick >= 0) begin
            grant_log.push_back(pick);
            acc_cyc.push_back(cyc);
        end
        if (req_ready != '0) ready_cycles++;
        if (mem_req_valid) mrv_cycles++;
        if (mem_req_valid && !prev_mrv) begin
            seen_addr  = mem_req_addr;
            seen_write = mem_req_write;
            seen_wdata = mem_req_wdata;
        end
        prev_mrv = mem_req_valid;
        if (resp_valid != '0) begin
            resp_pulses++;
            resp_cyc   = cyc;
            seen_vec   = resp_valid;
            seen_rdata = resp_rdata;
        end
        for (int i = 0; i < N; i++)
            if (reset) begin
                m_grants[i] = 0;
                m_waits[i]  = 0;
            end else if (exp_ready[i]) m_grants[i]++;
            else if (req_valid[i]) m_waits[i]++;

        // advance to the state after the coming clock edge
        m_resp = '0;
        if (reset) begin
            m_busy = 0; m_issued = 0; m_ptr = 0; m_rdata = '0; m_rd_known = 1;
        end else if (!m_busy) begin
            if (pick >= 0) begin
                m_busy = 1; m_issued = 0; m_grant = pick;
                m_write = req_write[pick];
                m_addr  = req_addr[pick*AW +: AW];
                m_wdata = req_wdata[pick*DW +: DW];
            end
        end else if (!m_issued) begin
            if (mem_req_ready) m_issued = 1;
        end else if (mem_resp_valid) begin
            m_resp[m_grant] = 1'b1;
            if (!m_write) begin
                m_rdata = mem_resp_rdata;
                m_rd_known = 1;
            end else m_rd_known = 0;
            m_ptr  = (m_grant + 1) % N;
            m_busy = 0;
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            step();
            n++;
            done = !m_busy && m_resp == '0 && req_valid == '0;
            for (int i = 0; i < N; i++) if (cnt[i] != 0) done = 0;
            if (!done && n > 400) begin
                chk({name, "_timeout"}, 64'd0, 64'd1);
                done = 1;
            end
        end
        step();
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; wr[i] = 0; caddr[i] = '0; cwd[i] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        step();
        reset = 0;

        // single client read on port 2, minimum latency
        caddr[2] = 21'h00100; wr[2] = 0; cnt[2] = 1;
        acc_cyc.delete();
        wait_quiet("single_read");
        chk("p2_addr", 64'(seen_addr), 64'h100);
        chk("p2_resp_vec", 64'(seen_vec), 64'b0100);
        chk("p2_rdata", seen_rdata, 64'hDEADBEEF_00000001);
        chk("p2_latency", 64'(resp_cyc - acc_cyc[0]), 64'd3);

        // all four ports continuously requesting after reset
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            caddr[i] = AW'(32'h1000 * (i + 1)); wr[i] = 0; cnt[i] = 3;
        end
        wait_quiet("all_ports");
        chk("rr_count", 64'(grant_log.size()), 64'd12);
        for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));

        // memory back-pressure for 5 cycles
        hold_ready = 5;
        mrv_cycles = 0; ready_cycles = 0;
        caddr[1] = 21'h00777; wr[1] = 0; cnt[1] = 1;
        wait_quiet("stall");
        chk("stall_mrv_cycles", 64'(mrv_cycles), 64'd6);
        chk("stall_ready_cycles", 64'(ready_cycles), 64'd1);

        // write on port 1
        resp_lat = 2;
        caddr[1] = 21'h0ABCD; wr[1] = 1; cwd[1] = 64'h1122334455667788; cnt[1] = 1;
        wait_quiet("write");
        chk("wr_write", 64'(seen_write), 64'd1);
        chk("wr_addr", 64'(seen_addr), 64'h0ABCD);
        chk("wr_wdata", seen_wdata, 64'h1122334455667788);
        chk("wr_resp_vec", 64'(seen_vec), 64'b0010);
        wr[1] = 0;

        // single client back-to-back
        resp_lat = 0;
        acc_cyc.delete();
        caddr[3] = 21'h00040; wr[3] = 0; cnt[3] = 3;
        wait_quiet("b2b");
        chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);

        // reset while waiting for the memory response
        resp_lat = 50;
        caddr[2] = 21'h00200; cnt[2] = 1;
        for (int n = 0; n < 30 && !(m_busy && m_issued); n++) step();
        chk("reached_wait", 64'(m_busy && m_issued), 64'd1);
        step();
        base = resp_pulses;
        reset = 1;
        step();
        reset = 0;
        step();
        resp_force = 1;
        step();
        resp_force = 0;
        step();
        step();
        chk("abandon_no_resp", 64'(resp_pulses - base), 64'd0);
        resp_lat = 0;
        grant_log.delete();
        cnt[1] = 1; cnt[0] = 1;
        wait_quiet("post_reset");
        chk("post_reset_first", 64'(grant_log[0]), 64'd0);
        chk("post_reset_second", 64'(grant_log[1]), 64'd1);

`ifdef MEM_ARB_STATS_EN
        do_reset();
        hold_ready = 1;
        cnt[0] = 10; cnt[3] = 10;
        wait_quiet("stats");
        chk("stat_grants0", 64'(stat_grants[0*32 +: 32]), 64'd10);
        chk("stat_grants3", 64'(stat_grants[3*32 +: 32]), 64'd10);
        chk("stat_waits0_nz", 64'(stat_waits[0*32 +: 32] != 0), 64'd1);
        chk("stat_waits3_nz", 64'(stat_waits[3*32 +: 32] != 0), 64'd1);
        chk("stat_waits0", 64'(stat_waits[0*32 +: 32]), 64'(m_waits[0]));
        chk("stat_waits3", 64'(stat_waits[3*32 +: 32]), 64'(m_waits[3]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
